// File: rtl/dom_and_pipe.sv
// Purpose: vectorised DOM AND gadget; NUM_SHARES Boolean shares per operand, WIDTH independent lanes.
// Latency: 2 cycles with OUT_REG=1 (blinded terms, then compressed shares), 1 cycle with OUT_REG=0.
// Backpressure: valid/ready; stages load only when empty or draining, and stalled stages hold bits and masks.
module dom_and_pipe #(
    parameter int NUM_SHARES = 2,
    parameter int WIDTH      = 8,
    parameter int OUT_REG    = 1,
    localparam int NUM_MASKS = NUM_SHARES * (NUM_SHARES - 1) / 2
) (
    input  logic                          ClkCI,
    input  logic                          RstRI,
    input  logic [NUM_SHARES*WIDTH-1:0]   LeftDI,
    input  logic [NUM_SHARES*WIDTH-1:0]   RightDI,
    input  logic [NUM_MASKS*WIDTH-1:0]    RandomDI,
    input  logic                          InValidSI,
    output logic                          InReadySO,
    output logic [NUM_SHARES*WIDTH-1:0]   OutDO,
    output logic                          OutValidSO,
    input  logic                          OutReadySI
);

    localparam int NS = NUM_SHARES;
    localparam int TW = NS * NS * WIDTH;

    if (NUM_SHARES < 2) begin : g_bad_shares
        $error("dom_and_pipe: NUM_SHARES must be at least 2");
    end

    logic [TW-1:0]          blinded;
    logic [TW-1:0]          term_q;
    logic                   v1_q;
    logic [NS*WIDTH-1:0]    comp;
    logic                   in_rdy;
    logic                   in_fire;
    logic                   s1_adv;

    // Cross terms L_i & R_j; off-diagonal pairs share one fresh mask so it cancels on recombination.
    for (genvar gi = 0; gi < NS; gi++) begin : g_row
        for (genvar gj = 0; gj < NS; gj++) begin : g_col
            localparam int LO = (gi < gj) ? gi : gj;
            localparam int HI = (gi < gj) ? gj : gi;
            localparam int MI = LO + HI * (HI - 1) / 2;
            if (gi == gj) begin : g_diag
                assign blinded[(gi*NS+gj)*WIDTH +: WIDTH] =
                    LeftDI[gi*WIDTH +: WIDTH] & RightDI[gj*WIDTH +: WIDTH];
            end else begin : g_cross
                assign blinded[(gi*NS+gj)*WIDTH +: WIDTH] =
                    (LeftDI[gi*WIDTH +: WIDTH] & RightDI[gj*WIDTH +: WIDTH]) ^
                    RandomDI[MI*WIDTH +: WIDTH];
            end
        end
    end

    // Compression only ever sees registered terms, so no cross-domain glitch path exists.
    always_comb begin
        comp = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NS; j++) begin
                comp[i*WIDTH +: WIDTH] = comp[i*WIDTH +: WIDTH] ^ term_q[(i*NS+j)*WIDTH +: WIDTH];
            end
        end
    end

    assign in_rdy    = ~v1_q | s1_adv;
    assign in_fire   = InValidSI & in_rdy;
    assign InReadySO = in_rdy;

    // Stage 1: blinded terms are captured once per accepted beat; randomness is consumed only here.
    always_ff @(posedge ClkCI or posedge RstRI) begin
        if (RstRI) begin
            v1_q   <= 1'b0;
            term_q <= '0;
        end else begin
            if (in_rdy) begin
                v1_q <= InValidSI;
            end
            if (in_fire) begin
                term_q <= blinded;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                v2_q;
        logic [NS*WIDTH-1:0] out_q;

        assign s1_adv     = v1_q & (~v2_q | OutReadySI);
        assign OutDO      = out_q;
        assign OutValidSO = v2_q;

        // Stage 2: compressed shares, loaded when empty or when the held beat leaves this cycle.
        always_ff @(posedge ClkCI or posedge RstRI) begin
            if (RstRI) begin
                v2_q  <= 1'b0;
                out_q <= '0;
            end else begin
                if (~v2_q | OutReadySI) begin
                    v2_q <= v1_q;
                end
                if (s1_adv) begin
                    out_q <= comp;
                end
            end
        end
    end else begin : g_out_comb
        assign s1_adv     = v1_q & OutReadySI;
        assign OutDO      = comp;
        assign OutValidSO = v1_q;
    end

endmodule

// File: tb/tb_dom_and_pipe.sv
// Purpose: self-checking bench for dom_and_pipe across four parameter sets.
// Latency: checks 2-cycle (OUT_REG=1) and 1-cycle (OUT_REG=0) result timing.
// Backpressure: random and directed stalls, mid-flight reset.
module tb_dom_and_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance: 3 shares, 8 lanes, registered output
    logic [23:0] a_left, a_right, a_rnd, a_out;
    logic        a_iv, a_ir, a_ov, a_or;
    // Worked-value instances: 2 shares, 4 lanes, both output styles
    logic [7:0]  w_left, w_right, b_out, c_out;
    logic [3:0]  w_rnd;
    logic        w_iv, w_or, b_ir, b_ov, c_ir, c_ov;
    // Mask-mapping instance: 4 shares, 1 lane
    logic [3:0]  d_left, d_right, d_out;
    logic [5:0]  d_rnd;
    logic        d_iv, d_ir, d_ov, d_or;

    dom_and_pipe #(.NUM_SHARES(3), .WIDTH(8), .OUT_REG(1)) u_dut_a (
        .ClkCI(clk), .RstRI(rst), .LeftDI(a_left), .RightDI(a_right), .RandomDI(a_rnd),
        .InValidSI(a_iv), .InReadySO(a_ir), .OutDO(a_out), .OutValidSO(a_ov), .OutReadySI(a_or));
    dom_and_pipe #(.NUM_SHARES(2), .WIDTH(4), .OUT_REG(1)) u_dut_b (
        .ClkCI(clk), .RstRI(rst), .LeftDI(w_left), .RightDI(w_right), .RandomDI(w_rnd),
        .InValidSI(w_iv), .InReadySO(b_ir), .OutDO(b_out), .OutValidSO(b_ov), .OutReadySI(w_or));
    dom_and_pipe #(.NUM_SHARES(2), .WIDTH(4), .OUT_REG(0)) u_dut_c (
        .ClkCI(clk), .RstRI(rst), .LeftDI(w_left), .RightDI(w_right), .RandomDI(w_rnd),
        .InValidSI(w_iv), .InReadySO(c_ir), .OutDO(c_out), .OutValidSO(c_ov), .OutReadySI(w_or));
    dom_and_pipe #(.NUM_SHARES(4), .WIDTH(1), .OUT_REG(0)) u_dut_d (
        .ClkCI(clk), .RstRI(rst), .LeftDI(d_left), .RightDI(d_right), .RandomDI(d_rnd),
        .InValidSI(d_iv), .InReadySO(d_ir), .OutDO(d_out), .OutValidSO(d_ov), .OutReadySI(d_or));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model for the 3-share instance: a FIFO of capacity 2 whose head
    // becomes visible one edge after capture, plus the share equations.
    typedef struct {
        logic [23:0] sh;
        logic [7:0]  um;
        int          t;
    } beat_t;
    beat_t q[$];
    bit          stall_prev = 1'b0;
    logic [23:0] out_prev   = '0;

    function automatic int mask_idx(input int i, input int j);
        int lo, hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo + hi * (hi - 1) / 2;
    endfunction

    function automatic logic [23:0] ref_shares(input logic [23:0] l, input logic [23:0] r,
                                               input logic [23:0] rnd);
        logic [23:0] o;
        o = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                o[i*8 +: 8] = o[i*8 +: 8] ^ (l[i*8 +: 8] & r[j*8 +: 8]);
                if (i != j) o[i*8 +: 8] = o[i*8 +: 8] ^ rnd[mask_idx(i, j)*8 +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] unmask3(input logic [23:0] v);
        return v[7:0] ^ v[15:8] ^ v[23:16];
    endfunction

    // One clock cycle on the main instance; called just after a falling edge.
    task automatic a_cycle(input bit iv, input logic [23:0] l, input logic [23:0] r,
                           input logic [23:0] rnd, input bit ordy, output bit fired);
        bit    exp_ov, exp_ir;
        beat_t b;
        a_iv = iv; a_left = l; a_right = r; a_rnd = rnd; a_or = ordy;
        #1;
        exp_ov = (q.size() > 0) && (edge_cnt - q[0].t >= 1);
        exp_ir = (q.size() < 2) || ordy;
        check("a_valid", a_ov, exp_ov);
        check("a_ready", a_ir, exp_ir);
        if (exp_ov && a_ov) begin
            check("a_shares", a_out, q[0].sh);
            check("a_unmasked", unmask3(a_out), q[0].um);
        end
        if (stall_prev) check("a_hold", a_out, out_prev);
        stall_prev = exp_ov && !ordy;
        out_prev   = a_out;
        if (exp_ov && ordy) void'(q.pop_front());
        fired = iv && exp_ir;
        if (fired) begin
            b.sh = ref_shares(l, r, rnd);
            b.um = unmask3(l) & unmask3(r);
            b.t  = edge_cnt + 1;
            q.push_back(b);
        end
        @(negedge clk);
    endtask

    logic [3:0]  pair_tab [6];
    logic [23:0] bp_l [3];
    logic [23:0] bp_r [3];

    initial begin
        bit          f;
        int          idx;
        logic [23:0] rnd_t;

        pair_tab = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};
        rst = 1'b1;
        a_iv = 0; a_left = '0; a_right = '0; a_rnd = '0; a_or = 1;
        w_iv = 0; w_left = '0; w_right = '0; w_rnd = '0; w_or = 1;
        d_iv = 0; d_left = '0; d_right = '0; d_rnd = '0; d_or = 1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_valid", a_ov, 1'b0);
        check("rst_a_out", a_out, 24'h0);
        check("rst_b_out", b_out, 8'h0);
        check("rst_d_valid", d_ov, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_a_ready", a_ir, 1'b1);
        @(negedge clk);

        // Worked value on both output styles
        w_left = 8'h6A; w_right = 8'h53; w_rnd = 4'h9; w_iv = 1; w_or = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            w_iv = 0;
            #1;
            check("wv_reg_valid", b_ov, (k == 2));
            check("wv_comb_valid", c_ov, (k == 1));
            if (k == 2) begin
                check("wv_reg_shares", b_out, 8'hFB);
                check("wv_reg_unmasked", b_out[3:0] ^ b_out[7:4], 4'h4);
            end
            if (k == 1) check("wv_comb_shares", c_out, 8'hFB);
        end

        // Mask mapping: each mask flips exactly the two shares of its pair
        d_left = 4'hF; d_right = 4'hF; d_or = 1;
        for (int m = 0; m <= 6; m++) begin
            d_rnd = (m < 6) ? 6'(1 << m) : 6'h0;
            d_iv  = 1;
            @(negedge clk);
            #1;
            check("mask_valid", d_ov, 1'b1);
            check("mask_shares", d_out, (m < 6) ? pair_tab[m % 6] : 4'h0);
            check("mask_unmasked", ^d_out, 1'b0);
        end
        d_iv = 0;
        @(negedge clk);

        // Streaming at full throughput
        for (int n = 0; n < 200; n++)
            a_cycle(1, $urandom, $urandom, $urandom, 1, f);
        repeat (3) a_cycle(0, '0, '0, $urandom, 1, f);

        // Directed backpressure: 5 stalled cycles, 3 beats, randomness toggling
        for (int n = 0; n < 3; n++) begin
            bp_l[n] = 24'($urandom);
            bp_r[n] = 24'($urandom);
        end
        idx   = 0;
        rnd_t = 24'h5A5A5A;
        for (int c = 0; c < 12; c++) begin
            rnd_t = ~rnd_t;
            a_cycle(idx < 3, bp_l[idx % 3], bp_r[idx % 3], rnd_t, (c >= 5), f);
            if (c == 4) check("bp_ready_low", a_ir, 1'b0);
            if (f) idx++;
        end
        check("bp_all_accepted", idx, 3);
        check("bp_drained", q.size(), 0);

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++)
            a_cycle($urandom_range(0, 1), $urandom, $urandom, $urandom, ($urandom_range(0, 3) != 0), f);
        repeat (3) a_cycle(0, '0, '0, '0, 1, f);

        // Asynchronous reset with two beats in flight
        a_cycle(1, $urandom, $urandom, $urandom, 0, f);
        a_cycle(1, $urandom, $urandom, $urandom, 0, f);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", a_ov, 1'b0);
        check("arst_out", a_out, 24'h0);
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) a_cycle(0, '0, '0, $urandom, 1, f);
        for (int n = 0; n < 20; n++) a_cycle(1, $urandom, $urandom, $urandom, 1, f);
        repeat (3) a_cycle(0, '0, '0, '0, 1, f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dom_and_pipe.md
Name: dom_and_pipe

Overview:
- Vectorised, parametrised domain-oriented masked (DOM) AND gadget.
- Operands are WIDTH-bit values split into NUM_SHARES Boolean shares; each bit lane is an independent DOM AND.
- Adds a valid/ready handshake with backpressure and an optional output compression register.
- Sits in masked datapaths such as S-box pipelines, where stalls must never recompute or re-blind already registered terms.

Parameters:
- NUM_SHARES, 2: number of Boolean shares per operand; must be >= 2 (elaboration error otherwise).
- WIDTH, 8: number of independent bit lanes.
- OUT_REG, 1: 1 = register compressed output shares (latency 2); 0 = output XOR-compressed combinationally from stage 1 (latency 1).
- NUM_MASKS (local), NUM_SHARES*(NUM_SHARES-1)/2: fresh mask bits per lane.

Ports:
- ClkCI  in  1  clock, rising edge.
- RstRI  in  1  asynchronous, active-high reset.
- LeftDI  in  NUM_SHARES*WIDTH  left operand; share s = LeftDI[s*WIDTH +: WIDTH].
- RightDI  in  NUM_SHARES*WIDTH  right operand; same layout as LeftDI.
- RandomDI  in  NUM_MASKS*WIDTH  fresh randomness; mask m of lane b = RandomDI[m*WIDTH + b].
- InValidSI  in  1  input beat valid.
- InReadySO  out  1  block accepts the input beat.
- OutDO  out  NUM_SHARES*WIDTH  product shares; share s = OutDO[s*WIDTH +: WIDTH].
- OutValidSO  out  1  output beat valid.
- OutReadySI  in  1  consumer accepts the output beat.

Behaviour:
- Cross terms per lane b and share pair (i,j): C[i][j] = L_i & R_j.
- Blinding: for i != j, XOR mask index m = min + max*(max-1)/2 into both C[i][j] and C[j][i]. Diagonal terms are unblinded.
- Stage 1 register holds all NUM_SHARES^2*WIDTH blinded terms plus valid bit V1. This register is mandatory; cross-domain terms are never combined before it.
- Compression: out share i = XOR over j of registered term [i][j].
- OUT_REG=1: stage 2 registers the compressed shares plus V2. OUT_REG=0: OutDO is driven combinationally from stage 1 and OutValidSO = V1.
- Handshakes:
  - Input fire = InValidSI & InReadySO.
  - Output fire = OutValidSO & OutReadySI.
  - Each stage loads when it is empty or its content leaves in the same cycle.
  - InReadySO = ~V1 | stage1_advances; combinational path from OutReadySI is allowed.
- Payload registers have clock enables:
  - They load only on the corresponding fire/advance.
  - Otherwise they hold their value, both bits and masks.
  - Stalls never re-sample LeftDI/RightDI/RandomDI.
- Randomness is consumed only on input fire. RandomDI is ignored in cycles without input fire.
- Full throughput: one beat per cycle when OutReadySI is held high. No bubbles are inserted.
- Simultaneous input fire and output fire on a full pipeline: the in-flight beat advances and the new beat is captured in the same edge. No loss, no duplication.
- Backpressure with a full pipeline: InReadySO=0; every register holds; OutDO is stable while OutValidSO=1 and OutReadySI=0.
- Reset (async, any time including mid-stall):
  - All payload registers and V1/V2 clear to 0.
  - OutDO=0, OutValidSO=0; InReadySO=1 once reset is released.
  - In-flight beats are discarded.
- OutDO while OutValidSO=0 is the held value and must not be sampled by the consumer.
- Correctness invariant: XOR of output shares = (XOR of Left shares) & (XOR of Right shares), per lane.

Test Plan:
- Worked value, NUM_SHARES=2, WIDTH=4, OUT_REG=1:
  - Stimulus: Left shares {0xA, 0x6} (L=0xC), Right shares {0x3, 0x5} (R=0x6), RandomDI=0x9, one beat, OutReadySI=1.
  - Required: after 2 cycles OutValidSO=1 for exactly 1 cycle with shares {0xB, 0xF}, whose XOR is 0x4.
- Same stimulus with OUT_REG=0 -> OutValidSO rises 1 cycle after input fire with identical shares {0xB, 0xF}.
- Streaming, NUM_SHARES=3, WIDTH=8, 200 random beats, OutReadySI=1:
  - Required: one result per cycle, in order, each unmasked output = L&R.
  - Required: InReadySO constantly 1.
- Backpressure:
  - Stimulus: OutReadySI=0 for 5 cycles with 3 beats offered while RandomDI toggles every cycle.
  - Required: pipeline fills (2 beats for OUT_REG=1), then InReadySO=0.
  - Required: OutDO bit-stable through the stall; after release, all 3 beats emerge in order with original shares.
- Reset mid-operation: assert RstRI asynchronously between clock edges with 2 beats in flight -> OutValidSO and OutDO drop to 0 immediately; after release no stale beat appears.
- Mask mapping, NUM_SHARES=4, WIDTH=1:
  - Stimulus: drive one RandomDI bit high at a time with all shares of L and R = 1.
  - Required: mask index m flips exactly output shares i and j of its pair (i,j). Unmasked result is always 0.
